// File: rtl/axi_lite_reg_slave.sv
// ----------------------------------------------------------------------------
// axi_lite_reg_slave
//
// AXI-lite register-bank slave for the 64-bit AXI-lite interface. Holds
// NUM_REGS byte-strobed 64-bit registers and exposes all of them as one flat
// bus. Out-of-range or misaligned accesses get an error response. One write
// and one read can be in flight at the same time, each with its own FSM.
//
// Ports
//   aclk, arst_n          clock (rising edge), async active-low reset
//   aw*                   write address channel (awid/awprot accepted, unused)
//   w*                    write data channel, wstrb bit i enables byte i
//   b*                    write response (bresp: 0 = OKAY, 1 = error)
//   ar*                   read address channel (arprot unused)
//   r*                    read data channel (rid echoes arid, rresp 0/1)
//   regs_q                all registers, reg k at [64k+63:64k]
// ----------------------------------------------------------------------------
module axi_lite_reg_slave #(
   parameter int NUM_REGS = 16
) (
   input  logic                   aclk,
   input  logic                   arst_n,
   input  logic [63:0]            awaddr,
   input  logic                   awvalid,
   input  logic [3:0]             awid,
   input  logic [2:0]             awprot,
   output logic                   awready,
   input  logic [63:0]            wdata,
   input  logic [7:0]             wstrb,
   input  logic                   wvalid,
   output logic                   wready,
   output logic                   bvalid,
   output logic                   bresp,
   input  logic                   bready,
   input  logic [63:0]            araddr,
   input  logic [3:0]             arid,
   input  logic [2:0]             arprot,
   input  logic                   arvalid,
   output logic                   arready,
   output logic [63:0]            rdata,
   output logic [3:0]             rid,
   output logic                   rresp,
   output logic                   rvalid,
   input  logic                   rready,
   output logic [NUM_REGS*64-1:0] regs_q
);

   localparam int IDX_W = $clog2(NUM_REGS);

   typedef enum logic [1:0] {W_ACCEPT, W_COMMIT, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_RESP}             r_state_e;

   // Error when not 8-byte aligned or beyond the last register.
   function automatic logic addr_err(input logic [63:0] addr);
      return (addr[2:0] != 3'b000) || (addr[63:IDX_W+3] != '0);
   endfunction

   // Sideband fields the bank has no use for.
   logic unused_sideband;
   assign unused_sideband = ^{awid, awprot, arprot};

   // ---------------------------------------------------------------- write
   w_state_e           w_state_q, w_state_d;
   logic               aw_got_q, aw_got_d;
   logic               w_got_q, w_got_d;
   logic               aw_err_q, aw_err_d;
   logic [IDX_W-1:0]   aw_idx_q, aw_idx_d;
   logic [63:0]        wdata_q, wdata_d;
   logic [7:0]         wstrb_q, wstrb_d;
   logic               awready_q, awready_d;
   logic               wready_q, wready_d;
   logic               bvalid_q, bvalid_d;
   logic               bresp_q, bresp_d;

   logic [63:0]        mem_q [NUM_REGS];

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      w_state_d = w_state_q;
      aw_got_d  = aw_got_q;
      w_got_d   = w_got_q;
      aw_err_d  = aw_err_q;
      aw_idx_d  = aw_idx_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      case (w_state_q)
         W_ACCEPT: begin
            // AW and W are captured independently, in either order.
            if (awvalid && awready_q) begin
               aw_got_d = 1'b1;
               aw_err_d = addr_err(awaddr);
               aw_idx_d = awaddr[IDX_W+2:3];
            end
            if (wvalid && wready_q) begin
               w_got_d = 1'b1;
               wdata_d = wdata;
               wstrb_d = wstrb;
            end
            if (aw_got_d && w_got_d) begin
               w_state_d = W_COMMIT;
               aw_got_d  = 1'b0;
               w_got_d   = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b0;
            end else begin
               // Ready is registered: it rises one edge after reset or idle.
               awready_d = !aw_got_d;
               wready_d  = !w_got_d;
            end
         end
         W_COMMIT: begin
            bvalid_d  = 1'b1;
            bresp_d   = aw_err_q;
            w_state_d = W_RESP;
         end
         W_RESP: begin
            if (bready) begin
               bvalid_d  = 1'b0;
               bresp_d   = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               w_state_d = W_ACCEPT;
            end
         end
         default: w_state_d = W_ACCEPT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of block order.
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         w_state_q <= W_ACCEPT;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         aw_err_q  <= 1'b0;
         aw_idx_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         aw_got_q  <= aw_got_d;
         w_got_q   <= w_got_d;
         aw_err_q  <= aw_err_d;
         aw_idx_q  <= aw_idx_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // NOTE: the register bank is architecturally visible and must read as zero
   // after reset, so it is reset like any other flop rather than left as RAM.
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         for (int k = 0; k < NUM_REGS; k++) mem_q[k] <= '0;
      end else if (w_state_q == W_COMMIT && !aw_err_q) begin
         for (int b = 0; b < 8; b++) begin
            if (wstrb_q[b]) mem_q[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
      assign regs_q[64*k +: 64] = mem_q[k];
   end

   // ----------------------------------------------------------------- read
   r_state_e    r_state_q, r_state_d;
   logic        arready_q, arready_d;
   logic        rvalid_q, rvalid_d;
   logic [63:0] rdata_q, rdata_d;
   logic [3:0]  rid_q, rid_d;
   logic        rresp_q, rresp_d;
   logic        ar_err;

   assign ar_err = addr_err(araddr);

   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rid_d     = rid_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (arvalid && arready_q) begin
               // Sampled from mem_q at the AR edge: a commit on this same
               // edge is not yet visible.
               rdata_d   = ar_err ? '0 : mem_q[araddr[IDX_W+2:3]];
               rresp_d   = ar_err;
               rid_d     = arid;
               rvalid_d  = 1'b1;
               arready_d = 1'b0;
               r_state_d = R_RESP;
            end else begin
               arready_d = 1'b1;
            end
         end
         R_RESP: begin
            if (rready) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rid_q     <= '0;
         rresp_q   <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rid_q     <= rid_d;
         rresp_q   <= rresp_d;
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rid     = rid_q;
   assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_reg_slave
//
// Self-checking bench for axi_lite_reg_slave: a table of directed write/read
// vectors with hand-computed results, plus hand-written sequences for split
// AW/W ordering, B backpressure, read/write collision and reset mid-write.
// Inputs change 1 ns after a rising edge; outputs are sampled on falling edges.
// ----------------------------------------------------------------------------
module tb_axi_lite_reg_slave;

   localparam int NUM_REGS = 16;
   localparam int IDX_W    = $clog2(NUM_REGS);

   logic                   aclk;
   logic                   arst_n;
   logic [63:0]            awaddr;
   logic                   awvalid;
   logic [3:0]             awid;
   logic [2:0]             awprot;
   logic                   awready;
   logic [63:0]            wdata;
   logic [7:0]             wstrb;
   logic                   wvalid;
   logic                   wready;
   logic                   bvalid;
   logic                   bresp;
   logic                   bready;
   logic [63:0]            araddr;
   logic [3:0]             arid;
   logic [2:0]             arprot;
   logic                   arvalid;
   logic                   arready;
   logic [63:0]            rdata;
   logic [3:0]             rid;
   logic                   rresp;
   logic                   rvalid;
   logic                   rready;
   logic [NUM_REGS*64-1:0] regs_q;

   axi_lite_reg_slave #(.NUM_REGS(NUM_REGS)) dut (
      .aclk(aclk), .arst_n(arst_n),
      .awaddr(awaddr), .awvalid(awvalid), .awid(awid), .awprot(awprot),
      .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bresp(bresp), .bready(bready),
      .araddr(araddr), .arid(arid), .arprot(arprot), .arvalid(arvalid),
      .arready(arready),
      .rdata(rdata), .rid(rid), .rresp(rresp), .rvalid(rvalid),
      .rready(rready),
      .regs_q(regs_q)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] model [NUM_REGS];

   typedef struct {
      bit          is_wr;
      logic [63:0] addr;
      logic [63:0] data;   // write data, or expected rdata for a read
      logic [7:0]  strb;
      logic [3:0]  id;
      logic        resp;   // expected bresp / rresp
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_regs(input string name);
      for (int k = 0; k < NUM_REGS; k++)
         check($sformatf("%s reg%0d", name, k), regs_q[64*k +: 64], model[k]);
   endtask

   task automatic model_write(input logic [63:0] addr, input logic [63:0] data,
                              input logic [7:0] strb, input logic resp);
      logic [IDX_W-1:0] idx;
      idx = addr[IDX_W+2:3];
      if (!resp)
         for (int b = 0; b < 8; b++)
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
   endtask

   // Drives AW and W until both handshake; W leads AW by w_lead cycles.
   // Returns 1 ns after the edge that completed the last handshake.
   task automatic write_issue(input logic [63:0] addr, input logic [63:0] data,
                              input logic [7:0] strb, input int w_lead,
                              input string name);
      bit aw_done = 0, w_done = 0, aw_now, w_now, split_checked = 0;
      int cyc = 0;
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      wvalid  = 1'b1;
      awvalid = (w_lead == 0);
      while (!(aw_done && w_done) && cyc < 50) begin
         @(negedge aclk);
         if (w_done && !aw_done && !split_checked) begin
            check({name, " wready after W"}, wready, 1'b0);
            check({name, " awready waiting AW"}, awready, 1'b1);
            split_checked = 1;
         end
         aw_now = awvalid && awready;
         w_now  = wvalid && wready;
         @(posedge aclk);
         #1;
         cyc++;
         if (aw_now) begin aw_done = 1; awvalid = 1'b0; end
         if (w_now)  begin w_done  = 1; wvalid  = 1'b0; end
         if (!aw_done && cyc >= w_lead) awvalid = 1'b1;
      end
      check({name, " handshake done"}, aw_done && w_done, 1'b1);
   endtask

   // Waits for B, checks latency/response/registers, optional backpressure.
   task automatic wait_bresp(input logic exp_resp, input int hold,
                             input string name);
      int n = 0;
      if (hold > 0) bready = 1'b0;
      do begin
         @(negedge aclk);
         n++;
      end while (!bvalid && n < 20);
      check({name, " b latency"}, n, 2);
      check({name, " bresp"}, bresp, exp_resp);
      check_regs(name);
      for (int i = 0; i < hold; i++) begin
         @(negedge aclk);
         check({name, " held bvalid"}, bvalid, 1'b1);
         check({name, " held bresp"}, bresp, exp_resp);
         check({name, " held readies"}, {awready, wready}, 2'b00);
      end
      bready = 1'b1;
      @(posedge aclk);
      #1;
      @(negedge aclk);
      check({name, " readies back"}, {awready, wready, bvalid}, 3'b110);
      @(posedge aclk);
      #1;
   endtask

   task automatic write_txn(input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input int w_lead,
                            input logic exp_resp, input int hold,
                            input string name);
      model_write(addr, data, strb, exp_resp);
      write_issue(addr, data, strb, w_lead, name);
      wait_bresp(exp_resp, hold, name);
   endtask

   task automatic read_txn(input logic [63:0] addr, input logic [3:0] id,
                           input logic [63:0] exp_data, input logic exp_resp,
                           input string name);
      bit hs = 0;
      int n = 0;
      araddr  = addr;
      arid    = id;
      arvalid = 1'b1;
      while (!hs && n < 20) begin
         @(negedge aclk);
         hs = arready;
         @(posedge aclk);
         #1;
         n++;
      end
      arvalid = 1'b0;
      check({name, " ar handshake"}, hs, 1'b1);
      @(negedge aclk);
      check({name, " rvalid"}, rvalid, 1'b1);
      check({name, " arready low"}, arready, 1'b0);
      check({name, " rdata"}, rdata, exp_data);
      check({name, " rid"}, rid, id);
      check({name, " rresp"}, rresp, exp_resp);
      @(posedge aclk);
      #1;
      @(negedge aclk);
      check({name, " arready back"}, {arready, rvalid}, 2'b10);
      @(posedge aclk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      arst_n  = 1'b0;
      awaddr  = '0; awvalid = 1'b0; awid = 4'h0; awprot = 3'b0;
      wdata   = '0; wstrb   = '0;   wvalid = 1'b0;
      bready  = 1'b1;
      araddr  = '0; arid    = 4'h0; arprot = 3'b0; arvalid = 1'b0;
      rready  = 1'b1;
      for (int k = 0; k < NUM_REGS; k++) model[k] = '0;

      vecs[0]  = '{1'b1, 64'h08, 64'h1122334455667788, 8'hFF, 4'h0, 1'b0};
      vecs[1]  = '{1'b0, 64'h08, 64'h1122334455667788, 8'h00, 4'h5, 1'b0};
      vecs[2]  = '{1'b1, 64'h80, 64'hCAFE_CAFE_CAFE_CAFE, 8'hFF, 4'h0, 1'b1};
      vecs[3]  = '{1'b1, 64'h04, 64'hBEEF_BEEF_BEEF_BEEF, 8'hFF, 4'h0, 1'b1};
      vecs[4]  = '{1'b0, 64'h80, 64'h0, 8'h00, 4'h3, 1'b0};
      vecs[5]  = '{1'b1, 64'h78, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 4'h0, 1'b0};
      vecs[6]  = '{1'b0, 64'h78, 64'hA5A5_A5A5_A5A5_A5A5, 8'h00, 4'hF, 1'b0};
      vecs[7]  = '{1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hF0, 4'h0, 1'b0};
      vecs[8]  = '{1'b0, 64'h10, 64'hDEADBEEF_00000000, 8'h00, 4'h2, 1'b0};
      vecs[9]  = '{1'b1, 64'h10, 64'h0, 8'h00, 4'h0, 1'b0};
      vecs[10] = '{1'b0, 64'h10, 64'hDEADBEEF_00000000, 8'h00, 4'h9, 1'b0};
      vecs[11] = '{1'b0, 64'h7F, 64'h0, 8'h00, 4'h1, 1'b1};
      vecs[12] = '{1'b0, 64'hFFFF_0000_0000_0000, 64'h0, 8'h00, 4'h6, 1'b1};
      vecs[4].resp = 1'b1;

      // Reset state.
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst readies", {awready, wready, arready}, 3'b000);
      check("rst valids", {bvalid, rvalid}, 2'b00);
      check("rst resps", {bresp, rresp}, 2'b00);
      check("rst rdata", rdata, 64'h0);
      check("rst rid", rid, 4'h0);
      check("rst regs", |regs_q, 1'b0);
      arst_n = 1'b1;
      #1;
      check("release readies pre-edge", {awready, wready, arready}, 3'b000);
      @(posedge aclk);
      #1;
      check("release readies post-edge", {awready, wready, arready}, 3'b111);

      // Table-driven vectors.
      for (int i = 0; i < $size(vecs); i++) begin
         if (vecs[i].is_wr)
            write_txn(vecs[i].addr, vecs[i].data, vecs[i].strb, 0,
                      vecs[i].resp, 0, $sformatf("vec%0d wr", i));
         else
            read_txn(vecs[i].addr, vecs[i].id, vecs[i].data, vecs[i].resp,
                     $sformatf("vec%0d rd", i));
      end

      // W three cycles ahead of AW, lower-half strobe onto reg 1.
      write_txn(64'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 3, 1'b0, 0, "w_first");
      read_txn(64'h08, 4'hA, 64'h11223344_FFFFFFFF, 1'b0, "w_first rd");

      // B backpressure for 10 cycles on a write to reg 3.
      write_txn(64'h18, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 0, 1'b0, 10, "bp");
      read_txn(64'h18, 4'hC, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, "bp rd");

      // AR on the same edge as a commit to reg 2: old value returned.
      model_write(64'h10, 64'h01234567_89ABCDEF, 8'hFF, 1'b0);
      write_issue(64'h10, 64'h01234567_89ABCDEF, 8'hFF, 0, "coll");
      araddr  = 64'h10;
      arid    = 4'h7;
      arvalid = 1'b1;
      @(negedge aclk);
      check("coll arready", arready, 1'b1);
      check("coll bvalid pre-commit", bvalid, 1'b0);
      @(posedge aclk);
      #1;
      arvalid = 1'b0;
      @(negedge aclk);
      check("coll rvalid", rvalid, 1'b1);
      check("coll rdata old", rdata, 64'hDEADBEEF_00000000);
      check("coll rid", rid, 4'h7);
      check("coll rresp", rresp, 1'b0);
      check("coll bvalid", bvalid, 1'b1);
      check("coll reg2 new", regs_q[64*2 +: 64], 64'h01234567_89ABCDEF);
      @(posedge aclk);
      #1;
      @(negedge aclk);
      check("coll valids clear", {bvalid, rvalid}, 2'b00);
      @(posedge aclk);
      #1;
      read_txn(64'h10, 4'h8, 64'h01234567_89ABCDEF, 1'b0, "coll followup");

      // Reset while a write response is pending.
      bready = 1'b0;
      write_issue(64'h20, 64'h5555_5555_5555_5555, 8'hFF, 0, "mid");
      repeat (2) @(negedge aclk);
      check("mid bvalid pending", bvalid, 1'b1);
      #2;
      arst_n = 1'b0;
      #1;
      check("mid rst bvalid", bvalid, 1'b0);
      check("mid rst readies", {awready, wready, arready}, 3'b000);
      check("mid rst regs", |regs_q, 1'b0);
      for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      arst_n = 1'b1;
      bready = 1'b1;
      #1;
      check("mid release pre-edge", {awready, wready, arready, bvalid}, 4'b0000);
      @(posedge aclk);
      #1;
      check("mid release post-edge", {awready, wready, arready, bvalid}, 4'b1110);
      read_txn(64'h08, 4'h3, 64'h0, 1'b0, "post-rst rd");
      read_txn(64'h20, 4'h4, 64'h0, 1'b0, "post-rst reg4");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
